// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide scheduler.
package md_pkg;

    localparam int unsigned MD_OP_W     = 3;
    localparam int unsigned MD_MULT_CYC = 5;
    localparam int unsigned MD_DIV_CYC  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that open a busy window.
    function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces {hi, lo} for the selected op
// and flags a zero divisor.
module md_arith
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [MD_OP_W-1:0]  op,
    input  logic [WIDTH-1:0]    rs,
    input  logic [WIDTH-1:0]    rt,
    output logic [2*WIDTH-1:0]  res,
    output logic                div_zero
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    rs_sx, rt_sx, rs_zx, rt_zx;
    logic [W2-1:0]    prod_s, prod_u;
    logic [WIDTH-1:0] quot_s, rem_s, quot_u, rem_u;
    logic [WIDTH-1:0] min_neg;
    logic             div_ovf;

    assign rs_sx = {{WIDTH{rs[WIDTH-1]}}, rs};
    assign rt_sx = {{WIDTH{rt[WIDTH-1]}}, rt};
    assign rs_zx = {{WIDTH{1'b0}}, rs};
    assign rt_zx = {{WIDTH{1'b0}}, rt};

    // Low 2W bits of the sign-extended product equal the signed product.
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = rs_zx * rt_zx;

    assign quot_s = $signed(rs) / $signed(rt);
    assign rem_s  = $signed(rs) % $signed(rt);
    assign quot_u = rs / rt;
    assign rem_u  = rs % rt;

    assign min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    assign div_ovf  = (rs == min_neg) && (rt == {WIDTH{1'b1}});
    assign div_zero = (rt == '0);

    always_comb begin
        res = '0;
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                if (div_zero)     res = {rs, {WIDTH{1'b1}}};
                else if (div_ovf) res = {{WIDTH{1'b0}}, min_neg};
                else              res = {rem_s, quot_s};
            end
            MD_DIVU: begin
                if (div_zero) res = {rs, {WIDTH{1'b1}}};
                else          res = {rem_u, quot_u};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: fixed-latency busy window, HI/LO commit and D-stage stall request.
// Optional macro MD_DIVZERO_EN: divide by zero takes a 1-cycle window and leaves HI/LO unchanged.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYC,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MD_OP_W-1:0]  md_op,
    input  logic                md_start,
    input  logic [WIDTH-1:0]    rs_val,
    input  logic [WIDTH-1:0]    rt_val,
    input  logic                D_is_md,
    output logic                busy,
    output logic                stall_md,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

`ifdef MD_DIVZERO_EN
    localparam bit DZ_SHORT = 1'b1;
`else
    localparam bit DZ_SHORT = 1'b0;
`endif

    md_state_e          state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0]   hi_t, lo_t, hi_t_nx, lo_t_nx;
    logic [WIDTH-1:0]   hi_nx, lo_nx;
    logic               commit, commit_nx;
    logic [2*WIDTH-1:0] res;
    logic               div_zero;
    logic               is_arith, is_div, dz_short;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op       (md_op),
        .rs       (rs_val),
        .rt       (rt_val),
        .res      (res),
        .div_zero (div_zero)
    );

    assign is_arith = md_is_arith(md_op);
    assign is_div   = md_is_div(md_op);
    assign dz_short = DZ_SHORT & is_div & div_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_t   <= '0;
            lo_t   <= '0;
            commit <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi_t   <= hi_t_nx;
            lo_t   <= lo_t_nx;
            commit <= commit_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
            busy   <= (state_nx == ST_RUN);
        end
    end

    // Starts are only accepted in IDLE; anything arriving during RUN is dropped.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_t_nx   = hi_t;
        lo_t_nx   = lo_t;
        commit_nx = commit;
        hi_nx     = hi;
        lo_nx     = lo;
        case (state)
            ST_IDLE: begin
                if (md_start) begin
                    if (is_arith) begin
                        state_nx             = ST_RUN;
                        {hi_t_nx, lo_t_nx}   = res;
                        commit_nx            = !dz_short;
                        if (dz_short)    cnt_nx = '0;
                        else if (is_div) cnt_nx = CNT_W'(DIV_CYCLES - 1);
                        else             cnt_nx = CNT_W'(MULT_CYCLES - 1);
                    end else if (md_op == MD_MTHI) begin
                        hi_nx = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_nx = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                    if (commit) begin
                        hi_nx = hi_t;
                        lo_nx = lo_t;
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Hazard-unit stall request, combinational on the current E/D inputs.
    assign stall_md = !reset & D_is_md & (busy | (md_start & is_arith));

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: a transaction-level model predicts each cycle's outputs.
module tb_md_sched;
    import md_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned MULN = 5;
    localparam int unsigned DIVN = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    md_op = 3'd0;
    logic          md_start = 1'b0;
    logic [W-1:0]  rs_val = '0;
    logic [W-1:0]  rt_val = '0;
    logic          D_is_md = 1'b0;
    logic          busy, stall_md;
    logic [W-1:0]  hi, lo;

    md_sched #(.WIDTH(W), .MULT_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .md_start (md_start),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .D_is_md  (D_is_md),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        stall;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int          busy_left = 0;
    logic [31:0] ref_hi = '0, ref_lo = '0;
    logic [31:0] pend_hi = '0, pend_lo = '0;
    bit          pend_commit = 0;

    function automatic bit op_arith(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ma, mb;
        logic [63:0] out;
        out = '0;
        case (op)
            3'd1: out = 64'(longint'($signed(a)) * longint'($signed(b)));
            3'd2: out = {32'd0, a} * {32'd0, b};
            3'd3: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ma = (sa < 0) ? longint'(-sa) : sa;
                mb = (sb < 0) ? longint'(-sb) : sb;
                q  = longint'(ma / mb);
                r  = longint'(ma % mb);
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                out = {r[31:0], q[31:0]};
            end
            3'd4: out = {a % b, a / b};
            default: out = '0;
        endcase
        return out;
    endfunction

    task automatic push_expect(input bit in_reset);
        exp_t e;
        e.busy  = (busy_left > 0);
        e.stall = !in_reset && D_is_md && ((busy_left > 0) || (md_start && op_arith(md_op)));
        e.hi    = ref_hi;
        e.lo    = ref_lo;
        exp_q.push_back(e);
    endtask

    // Effect of the current cycle's inputs at the closing clock edge.
    task automatic model_step();
        logic [63:0] r;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0 && pend_commit) begin
                ref_hi = pend_hi;
                ref_lo = pend_lo;
            end
        end else if (md_start) begin
            if (op_arith(md_op)) begin
                if ((md_op == 3'd3 || md_op == 3'd4) && rt_val == 0) begin
`ifdef MD_DIVZERO_EN
                    busy_left   = 1;
                    pend_commit = 0;
`else
                    busy_left   = DIVN;
                    pend_commit = 1;
                    pend_hi     = rs_val;
                    pend_lo     = 32'hFFFF_FFFF;
`endif
                end else begin
                    r           = ref_result(md_op, rs_val, rt_val);
                    busy_left   = (md_op >= 3'd3) ? DIVN : MULN;
                    pend_commit = 1;
                    pend_hi     = r[63:32];
                    pend_lo     = r[31:0];
                end
            end else if (md_op == 3'd5) begin
                ref_hi = rs_val;
            end else if (md_op == 3'd6) begin
                ref_lo = rs_val;
            end
        end
    endtask

    task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit d);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        md_start = st;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        D_is_md  = d;
        push_expect(1'b0);
        model_step();
    endtask

    task automatic idle(input int n, input bit d);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 32'd0, d);
    endtask

    // Reset cycles drive a live-looking MULT with D_is_md set; stall must stay low.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset       = 1'b1;
            md_start    = 1'b1;
            md_op       = 3'd1;
            rs_val      = 32'd9;
            rt_val      = 32'd9;
            D_is_md     = 1'b1;
            busy_left   = 0;
            pend_commit = 0;
            ref_hi      = '0;
            ref_lo      = '0;
            push_expect(1'b1);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy",     32'(busy),     32'(e.busy));
                check("stall_md", 32'(stall_md), 32'(e.stall));
                check("hi",       hi,            e.hi);
                check("lo",       lo,            e.lo);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2 reset = 1'b1;
        do_reset(2);

        // Signed multiply of a negative operand
        drive(1, 3'd1, 32'hFFFF_FFFD, 32'd7, 0);
        idle(7, 0);
        // Signed and unsigned divide, including the overflow case
        drive(1, 3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        idle(11, 0);
        drive(1, 3'd4, 32'd7, 32'd2, 0);
        idle(11, 0);
        drive(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(11, 0);
        // MULTU with an MFLO waiting in D, then a non-md instr in D during a run
        drive(1, 3'd2, 32'd3, 32'd5, 1);
        idle(7, 1);
        drive(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle(7, 0);
        // MTHI/MTLO, then starts during RUN are ignored
        drive(1, 3'd5, 32'h1234, 32'd0, 0);
        drive(1, 3'd6, 32'h5678, 32'd0, 1);
        drive(1, 3'd1, 32'd2, 32'd3, 0);
        drive(1, 3'd6, 32'hDEAD, 32'd0, 1);
        drive(1, 3'd1, 32'd9, 32'd9, 0);
        idle(5, 0);
        // Divide by zero
        drive(1, 3'd3, 32'd5, 32'd0, 0);
        idle(11, 0);
        drive(1, 3'd4, 32'd6, 32'd0, 0);
        idle(11, 0);
        // Reset in the middle of a DIV
        drive(1, 3'd3, 32'd100, 32'd7, 0);
        idle(2, 0);
        do_reset(2);
        idle(12, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else drive($urandom_range(0, 3) != 0, 3'($urandom_range(1, 6)), rand_val(), rand_val(),
                       $urandom_range(0, 1) == 1);
        end
        idle(12, 0);

        repeat (3) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
